// File: rtl/audio_sfx_sched.sv
// audio_sfx_sched: fixed-priority sound-effect scheduler driving the PWM stage's pulsewidth/mute.
// Optional feature: define AUDIO_SFX_PREEMPT_EN to let a higher-priority request cut the active sound.
`ifndef BITRES
`define BITRES 4
`endif

module audio_sfx_sched #(
    parameter int HP_W  = 12,
    parameter int DUR_W = 16
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 sfx_en,
    input  logic [3:0]           req,
    input  logic [4*HP_W-1:0]    halfper,
    input  logic [4*DUR_W-1:0]   dur,
    input  logic [`BITRES-1:0]   vol,
    output logic [`BITRES-1:0]   pwm_pulsewidth,
    output logic                 pwm_mute,
    output logic [3:0]           grant,
    output logic [3:0]           done,
    output logic                 busy
);

    localparam int BITRES = `BITRES;
    localparam logic [HP_W-1:0]  HP_ONE  = HP_W'(1);
    localparam logic [DUR_W-1:0] DUR_ONE = DUR_W'(1);

    typedef enum logic [1:0] {S_IDLE, S_PLAY, S_GAP} state_t;

    state_t              state_q, state_d;
    logic [BITRES-1:0]   fcnt_q, fcnt_d;
    logic [3:0]          pend_q, pend_d;
    logic [1:0]          act_q, act_d;
    logic [HP_W-1:0]     phase_q, phase_d;
    logic [DUR_W-1:0]    remain_q, remain_d;
    logic                level_q, level_d;
    logic [BITRES-1:0]   pw_q, pw_d;
    logic                mute_q, mute_d;
    logic [3:0]          grant_q, grant_d;
    logic [3:0]          done_q, done_d;
    logic                busy_q, busy_d;

    logic                ftick;
    logic                load;
    logic                lvl;
    logic [1:0]          nxt_idx;
    logic [HP_W-1:0]     hp_arr [4];
    logic [DUR_W-1:0]    dur_arr [4];

    function automatic logic [HP_W-1:0] clamp_hp(input logic [HP_W-1:0] v);
        return (v == '0) ? HP_ONE : v;
    endfunction

    function automatic logic [DUR_W-1:0] clamp_dur(input logic [DUR_W-1:0] v);
        return (v == '0) ? DUR_ONE : v;
    endfunction

    assign ftick = &fcnt_q;

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            hp_arr[i]  = halfper[i*HP_W +: HP_W];
            dur_arr[i] = dur[i*DUR_W +: DUR_W];
        end
    end

    // Lowest set pending bit wins.
    always_comb begin
        nxt_idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (pend_q[i]) nxt_idx = 2'(i);
        end
    end

`ifdef AUDIO_SFX_PREEMPT_EN
    logic [3:0] lower_mask;
    logic       pre_hit;
    assign lower_mask = 4'((4'd1 << act_q) - 4'd1);
    assign pre_hit    = |(pend_q & lower_mask);
`endif

    always_comb begin
        state_d  = state_q;
        fcnt_d   = fcnt_q + 1'b1;
        pend_d   = pend_q | req;
        act_d    = act_q;
        phase_d  = phase_q;
        remain_d = remain_q;
        level_d  = level_q;
        pw_d     = pw_q;
        mute_d   = mute_q;
        grant_d  = grant_q;
        done_d   = 4'b0000;
        load     = 1'b0;
        lvl      = level_q;

        if (!sfx_en) begin
            state_d = S_IDLE;
            pend_d  = 4'b0000;
            grant_d = 4'b0000;
            mute_d  = 1'b1;
            pw_d    = '0;
        end else if (ftick) begin
            case (state_q)
                S_IDLE: begin
                    if (|pend_q) load = 1'b1;
                end
                S_PLAY: begin
`ifdef AUDIO_SFX_PREEMPT_EN
                    if (pre_hit) begin
                        load = 1'b1;
                    end else
`endif
                    begin
                        remain_d = remain_q - 1'b1;
                        if (remain_q == DUR_ONE) begin
                            state_d = S_GAP;
                            pw_d    = '0;
                        end else begin
                            phase_d = phase_q - 1'b1;
                            if (phase_q == HP_ONE) begin
                                lvl     = ~level_q;
                                phase_d = clamp_hp(hp_arr[act_q]);
                            end
                            level_d = lvl;
                            pw_d    = lvl ? vol : '0;
                        end
                    end
                end
                S_GAP: begin
`ifdef AUDIO_SFX_PREEMPT_EN
                    if (pre_hit) begin
                        load = 1'b1;
                    end else
`endif
                    begin
                        done_d  = grant_q;
                        grant_d = 4'b0000;
                        if (|pend_q) begin
                            load = 1'b1;
                        end else begin
                            state_d = S_IDLE;
                            mute_d  = 1'b1;
                            pw_d    = '0;
                        end
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end

        // A req for the requester being loaded this cycle is absorbed by the load.
        if (load) begin
            state_d         = S_PLAY;
            act_d           = nxt_idx;
            phase_d         = clamp_hp(hp_arr[nxt_idx]);
            remain_d        = clamp_dur(dur_arr[nxt_idx]);
            level_d         = 1'b1;
            pw_d            = vol;
            mute_d          = 1'b0;
            grant_d         = 4'(4'd1 << nxt_idx);
            pend_d[nxt_idx] = 1'b0;
        end

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= S_IDLE;
            fcnt_q   <= '0;
            pend_q   <= 4'b0000;
            act_q    <= 2'd0;
            phase_q  <= HP_ONE;
            remain_q <= DUR_ONE;
            level_q  <= 1'b0;
            pw_q     <= '0;
            mute_q   <= 1'b1;
            grant_q  <= 4'b0000;
            done_q   <= 4'b0000;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            fcnt_q   <= fcnt_d;
            pend_q   <= pend_d;
            act_q    <= act_d;
            phase_q  <= phase_d;
            remain_q <= remain_d;
            level_q  <= level_d;
            pw_q     <= pw_d;
            mute_q   <= mute_d;
            grant_q  <= grant_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
        end
    end

    assign pwm_pulsewidth = pw_q;
    assign pwm_mute       = mute_q;
    assign grant          = grant_q;
    assign done           = done_q;
    assign busy           = busy_q;

endmodule

// File: tb/tb_audio_sfx_sched.sv
// Directed bench for audio_sfx_sched with 16-clock frames: vector table plus multi-cycle sequences.
`timescale 1ns/1ps
`ifndef BITRES
`define BITRES 4
`endif

module tb_audio_sfx_sched;

    localparam int HP_W  = 12;
    localparam int DUR_W = 16;
    localparam int BR    = `BITRES;
    localparam int FRAME = 1 << BR;

    logic                 clk = 1'b0;
    logic                 resetn = 1'b0;
    logic                 sfx_en = 1'b1;
    logic [3:0]           req = 4'b0000;
    logic [4*HP_W-1:0]    halfper = '0;
    logic [4*DUR_W-1:0]   dur = '0;
    logic [BR-1:0]        vol = '0;
    logic [BR-1:0]        pwm_pulsewidth;
    logic                 pwm_mute;
    logic [3:0]           grant;
    logic [3:0]           done;
    logic                 busy;

    always #5 clk = ~clk;

    audio_sfx_sched #(.HP_W(HP_W), .DUR_W(DUR_W)) dut (
        .clk(clk), .resetn(resetn), .sfx_en(sfx_en), .req(req),
        .halfper(halfper), .dur(dur), .vol(vol),
        .pwm_pulsewidth(pwm_pulsewidth), .pwm_mute(pwm_mute),
        .grant(grant), .done(done), .busy(busy)
    );

    // Bench copy of the frame position: cyc % FRAME equals the DUT's frame counter.
    int cyc;
    always @(posedge clk or negedge resetn) begin
        if (!resetn) cyc <= 0;
        else         cyc <= cyc + 1;
    end

    int  d3cnt = 0;
    int  mon_bad = 0;
    logic mon_on = 1'b0;
    always @(posedge clk) begin
        if (done[3]) d3cnt <= d3cnt + 1;
        if (mon_on && (!pwm_mute || done != 4'b0000 || busy)) mon_bad <= mon_bad + 1;
    end

    typedef struct {
        logic             en;
        logic [3:0]       rq;
        logic [HP_W-1:0]  hp;
        logic [DUR_W-1:0] du;
        logic [BR-1:0]    vl;
        int               nclk;
        logic [BR-1:0]    e_pw;
        logic             e_mute;
        logic [3:0]       e_grant;
        logic [3:0]       e_done;
        logic             e_busy;
    } vec_t;

    vec_t vt [18];
    int nvec  = 0;
    int nfail = 0;

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic goto_ofs(input int ph);
        while ((cyc % FRAME) != ph) @(negedge clk);
    endtask

    task automatic check(input string name, input logic [BR-1:0] pw, input logic mute,
                         input logic [3:0] g, input logic [3:0] d, input logic b);
        nvec++;
        if (pwm_pulsewidth !== pw || pwm_mute !== mute || grant !== g || done !== d || busy !== b) begin
            nfail++;
            $display("FAIL %s: got pw=%0d mute=%b grant=%b done=%b busy=%b, want pw=%0d mute=%b grant=%b done=%b busy=%b",
                     name, pwm_pulsewidth, pwm_mute, grant, done, busy, pw, mute, g, d, b);
        end
    endtask

    task automatic check_int(input string name, input int got, input int want);
        nvec++;
        if (got != want) begin
            nfail++;
            $display("FAIL %s: got %0d, want %0d", name, got, want);
        end
    endtask

    int bad;
    int d3_base;

    initial begin
        // en, req, hp, dur, vol, nclk | pw, mute, grant, done, busy
        vt[0]  = '{1'b1, 4'b0100, 12'd2, 16'd6, 4'd12, 1,  4'd0,  1'b1, 4'b0000, 4'b0000, 1'b0};
        vt[1]  = '{1'b1, 4'b0000, 12'd2, 16'd6, 4'd12, 7,  4'd12, 1'b0, 4'b0100, 4'b0000, 1'b1};
        vt[2]  = '{1'b1, 4'b0000, 12'd2, 16'd6, 4'd12, 16, 4'd12, 1'b0, 4'b0100, 4'b0000, 1'b1};
        vt[3]  = '{1'b1, 4'b0000, 12'd2, 16'd6, 4'd12, 16, 4'd0,  1'b0, 4'b0100, 4'b0000, 1'b1};
        vt[4]  = '{1'b1, 4'b0000, 12'd2, 16'd6, 4'd12, 16, 4'd0,  1'b0, 4'b0100, 4'b0000, 1'b1};
        vt[5]  = '{1'b1, 4'b0000, 12'd2, 16'd6, 4'd12, 16, 4'd12, 1'b0, 4'b0100, 4'b0000, 1'b1};
        vt[6]  = '{1'b1, 4'b0000, 12'd2, 16'd6, 4'd12, 16, 4'd12, 1'b0, 4'b0100, 4'b0000, 1'b1};
        vt[7]  = '{1'b1, 4'b0000, 12'd2, 16'd6, 4'd12, 16, 4'd0,  1'b0, 4'b0100, 4'b0000, 1'b1};
        vt[8]  = '{1'b1, 4'b0000, 12'd2, 16'd6, 4'd12, 15, 4'd0,  1'b0, 4'b0100, 4'b0000, 1'b1};
        vt[9]  = '{1'b1, 4'b0000, 12'd2, 16'd6, 4'd12, 1,  4'd0,  1'b1, 4'b0000, 4'b0100, 1'b0};
        vt[10] = '{1'b1, 4'b0000, 12'd2, 16'd6, 4'd12, 1,  4'd0,  1'b1, 4'b0000, 4'b0000, 1'b0};
        vt[11] = '{1'b1, 4'b0001, 12'd0, 16'd0, 4'd7,  1,  4'd0,  1'b1, 4'b0000, 4'b0000, 1'b0};
        vt[12] = '{1'b1, 4'b0001, 12'd0, 16'd0, 4'd7,  1,  4'd0,  1'b1, 4'b0000, 4'b0000, 1'b0};
        vt[13] = '{1'b1, 4'b0000, 12'd0, 16'd0, 4'd7,  13, 4'd7,  1'b0, 4'b0001, 4'b0000, 1'b1};
        vt[14] = '{1'b1, 4'b0000, 12'd0, 16'd0, 4'd7,  16, 4'd0,  1'b0, 4'b0001, 4'b0000, 1'b1};
        vt[15] = '{1'b1, 4'b0000, 12'd0, 16'd0, 4'd7,  16, 4'd0,  1'b1, 4'b0000, 4'b0001, 1'b0};
        vt[16] = '{1'b1, 4'b0000, 12'd0, 16'd0, 4'd7,  1,  4'd0,  1'b1, 4'b0000, 4'b0000, 1'b0};
        vt[17] = '{1'b1, 4'b0000, 12'd0, 16'd0, 4'd7,  47, 4'd0,  1'b1, 4'b0000, 4'b0000, 1'b0};

        // Reset state and idle after release
        step(3);
        check("reset_state", 4'd0, 1'b1, 4'b0000, 4'b0000, 1'b0);
        resetn = 1'b1;
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (pwm_mute !== 1'b1 || pwm_pulsewidth !== '0 || busy !== 1'b0) bad++;
        end
        check_int("idle_100_cycles_bad", bad, 0);

        // Single sound, then zero clamp and request merge
        goto_ofs(8);
        for (int i = 0; i < 18; i++) begin
            sfx_en  = vt[i].en;
            req     = vt[i].rq;
            halfper = {4{vt[i].hp}};
            dur     = {4{vt[i].du}};
            vol     = vt[i].vl;
            @(negedge clk);
            req = 4'b0000;
            step(vt[i].nclk - 1);
            check($sformatf("vec%0d", i), vt[i].e_pw, vt[i].e_mute, vt[i].e_grant, vt[i].e_done, vt[i].e_busy);
        end

        // Simultaneous requests: lower index first, next starts with done
        goto_ofs(4);
        halfper = {4{12'd1}};
        dur     = {4{16'd2}};
        vol     = 4'd5;
        req     = 4'b1010;
        @(negedge clk);
        req = 4'b0000;
        goto_ofs(0);
        check("simul_first", 4'd5, 1'b0, 4'b0010, 4'b0000, 1'b1);
        step(48);
        check("simul_handover", 4'd5, 1'b0, 4'b1000, 4'b0010, 1'b1);
        step(48);
        check("simul_end", 4'd0, 1'b1, 4'b0000, 4'b1000, 1'b0);

        // Higher-priority request arriving during a long sound
        goto_ofs(4);
        halfper = {4{12'd3}};
        dur     = {4{16'd20}};
        vol     = 4'd9;
        req     = 4'b1000;
        @(negedge clk);
        req = 4'b0000;
        goto_ofs(0);
        d3_base = d3cnt;
        check("pre_start", 4'd9, 1'b0, 4'b1000, 4'b0000, 1'b1);
        step(72);
        req = 4'b0001;
        @(negedge clk);
        req = 4'b0000;
        goto_ofs(0);
`ifdef AUDIO_SFX_PREEMPT_EN
        check("pre_frame6", 4'd9, 1'b0, 4'b0001, 4'b0000, 1'b1);
        step(256);
        check("pre_frame22", 4'd0, 1'b0, 4'b0001, 4'b0000, 1'b1);
        step(1);
        check_int("pre_done3_count", d3cnt - d3_base, 0);
`else
        check("pre_frame6", 4'd0, 1'b0, 4'b1000, 4'b0000, 1'b1);
        step(256);
        check("pre_frame22", 4'd9, 1'b0, 4'b0001, 4'b1000, 1'b1);
        step(1);
        check_int("pre_done3_count", d3cnt - d3_base, 1);
`endif

        // Abort with a pending request, then re-enable
        goto_ofs(4);
        req = 4'b0010;
        @(negedge clk);
        req    = 4'b0000;
        sfx_en = 1'b0;
        @(negedge clk);
        check("abort_next_cycle", 4'd0, 1'b1, 4'b0000, 4'b0000, 1'b0);
        mon_on = 1'b1;
        step(3);
        sfx_en = 1'b1;
        step(64);
        mon_on = 1'b0;
        check_int("abort_silent_bad_cycles", mon_bad, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule

// File: doc/audio_sfx_sched.md
# audio_sfx_sched

Sound-effect scheduler sitting directly in front of the single-channel PWM audio output stage. It accepts trigger pulses from four game-logic requesters (shot, invader hit, UFO, march) and arbitrates them by fixed priority. It generates a square-wave tone for the granted requester and drives the PWM stage's `pulsewidth` and `mute` inputs. All tone state advances once per PWM frame, so pulse-width changes never land mid-period.

## Interface
- `BITRES`: from `audio_values.vh`; not a module parameter. Width of the pulse-width value and of the internal frame counter.
- `HP_W`, default 12: width of each per-requester half-period, counted in frames.
- `DUR_W`, default 16: width of each per-requester duration, counted in frames.
- `clk` input, 1 bit: clock.
- `resetn` input, 1 bit: reset, asynchronous, active-low.
- `sfx_en` input, 1 bit: synchronous enable. Low aborts playback and clears all pending requests.
- `req` input, 4 bits: one-cycle trigger pulses. `req[0]` has the highest priority.
- `halfper` input, 4×`HP_W` bits: packed half-periods. Slice `i` belongs to requester `i`.
- `dur` input, 4×`DUR_W` bits: packed durations. Slice `i` belongs to requester `i`.
- `vol` input, `BITRES` bits: pulse width used during the high half of the tone.
- `pwm_pulsewidth` output, `BITRES` bits: to the PWM stage.
- `pwm_mute` output, 1 bit: to the PWM stage.
- `grant` output, 4 bits: one-hot active requester. All zeros when nothing is active.
- `done` output, 4 bits: one-cycle pulse when requester `i` finishes normally.
- `busy` output, 1 bit: high in PLAY or GAP.

## Operation
- **Frame counter `fcnt`.**
  - `BITRES` bits, free-running, wraps naturally.
  - `ftick` = (`fcnt` == all ones).
  - All state transitions happen only on `ftick`, except the `sfx_en` abort.
- **Pending register `pend[3:0]`.**
  - `req[i]` sets `pend[i]`.
  - `pend[i]` is cleared in the cycle requester `i` is loaded.
  - A `req[i]` in that same cycle is absorbed and does not re-set `pend[i]`.
  - Repeated `req[i]` pulses while `pend[i]` is already set merge into a single request.
- **FSM states: IDLE, PLAY, GAP.**
- **IDLE.**
  - Outputs: `pwm_mute`=1, `pwm_pulsewidth`=0, `grant`=0.
  - On `ftick` with `pend`≠0, load requester `a` = lowest set index.
  - Load: `phase`←max(`halfper[a]`,1), `remain`←max(`dur[a]`,1), `level`←1.
  - Then go to PLAY with `pwm_mute`=0 and `pwm_pulsewidth`=`vol`.
- **PLAY, on each `ftick`.**
  - `remain` decrements.
  - If `remain` was 1: go to GAP, `pwm_pulsewidth`←0.
  - Otherwise `phase` decrements. If `phase` was 1: toggle `level` and reload `phase` with max(`halfper[a]`,1).
  - `pwm_pulsewidth` ← `level` ? `vol` : 0. This uses the post-update `level`.
  - `halfper` and `vol` are sampled live. `dur` is sampled only at load.
- **GAP.**
  - One silent frame with `pwm_mute`=0 and `pwm_pulsewidth`=0.
  - On the next `ftick`: pulse `done[a]` for one cycle and clear `grant`.
  - In that same `ftick`, if `pend`≠0, load the next requester straight into PLAY; otherwise go to IDLE (`pwm_mute`←1).
- **`sfx_en`=0.**
  - Next cycle: state IDLE, `pend`=0, `grant`=0, `pwm_mute`=1, `pwm_pulsewidth`=0.
  - No `done` pulse is generated.
  - `req` is ignored while `sfx_en` is low.
  - `fcnt` keeps running.

## Timing
- **Reset values.**
  - Outputs: `pwm_mute`=1, `pwm_pulsewidth`=0, `grant`=0, `done`=0, `busy`=0.
  - Internal: `fcnt`=0, `pend`=0, state IDLE.
- **Registered outputs.** All outputs are registered. Values computed on an `ftick` cycle appear in the following cycle, which is the cycle `fcnt`=0.
- **Frame alignment.** `pwm_mute` falls in the cycle `fcnt`=0. The PWM stage's counter therefore restarts in lockstep with `fcnt`.
- **Request latency.** From `req[i]` in IDLE to audible output: up to 2^`BITRES` cycles (wait for `ftick`), plus 1 cycle.
- **Sound length.** Exactly `dur` frames of tone, plus 1 gap frame. `done` is asserted in the cycle `fcnt`=0 after the gap.
- **Tone period.** 2×`halfper`×2^`BITRES` clocks.

## Configuration
- `AUDIO_SFX_PREEMPT_EN` defined:
  - In PLAY or GAP, on `ftick`, if any `pend[j]` has `j` lower than the active index, the active sound is aborted with no `done` pulse.
  - Requester `j` is loaded immediately; no gap frame.
  - The aborted request is lost; it is not re-queued.
- `AUDIO_SFX_PREEMPT_EN` undefined: the active sound always runs to completion; higher-priority requests wait in `pend`.

## Test plan
All scenarios use `BITRES`=4 (16-clock frames).

1. **Reset idle.** Hold `resetn` low, then release with no `req` → `pwm_mute`=1, `pwm_pulsewidth`=0, `busy`=0 for 100 cycles.
2. **Single sound.** `req[2]` pulse, `halfper[2]`=2, `dur[2]`=6, `vol`=12:
   - `pwm_pulsewidth` sequence per frame is 12,12,0,0,12,12, then one frame of 0.
   - `done[2]` pulses once, 112 cycles after the first unmuted cycle.
   - `pwm_mute` then returns to 1.
3. **Simultaneous requests.** `req`=4'b1010 in one cycle → `grant`=4'b0010 first. `grant`=4'b1000 starts in the same cycle `done[1]` pulses.
4. **Preemption.** `req[3]` is playing with `dur`=20. Pulse `req[0]` at frame 5:
   - With the macro defined: `grant`=4'b0001 from the frame-6 boundary, and `done[3]` never pulses.
   - Without the macro: `grant[0]` waits until after `done[3]`.
5. **Abort.** Drop `sfx_en` mid-PLAY with `pend[1]` set → next cycle IDLE outputs, `pend`=0, no `done`. Raising `sfx_en` again produces no sound.
6. **Zero clamp and merge.** `halfper`=0 and `dur`=0 → a 1-frame tone at `vol`, then the gap frame, then `done`. A second `req` pulse while the first is still pending yields only one `done`.
